// File: rtl/pmp_phase_sched.sv
`default_nettype none
// ==========================================================================
// Module   : pmp_phase_sched
// Purpose  : Two-source set scheduler in front of cal_rel_phase; regenerates
//            package framing, tags the phase stream, flags framing errors.
// Revision : 1.0
// ==========================================================================
module pmp_phase_sched #(
   parameter int BEAT_SIZE  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int PKG_LEN    = 128,
   parameter int NUM_STEPS  = 4,
   parameter int OUT_LEN    = 256
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                            s0_axis_tvalid,
   output logic                            s0_axis_tready,
   input  logic                            s0_axis_tlast,
   input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                            s1_axis_tvalid,
   output logic                            s1_axis_tready,
   input  logic                            s1_axis_tlast,
   output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   input  logic [BEAT_SIZE*DATA_WIDTH-1:0] r_axis_tdata,
   input  logic                            r_axis_tvalid,
   output logic                            r_axis_tready,
   input  logic                            r_axis_tlast,
   output logic [BEAT_SIZE*DATA_WIDTH-1:0] o_axis_tdata,
   output logic                            o_axis_tvalid,
   input  logic                            o_axis_tready,
   output logic                            o_axis_tlast,
   output logic                            o_axis_tdest,
   output logic                            busy,
   output logic                            set_done,
   output logic                            err_len,
   output logic                            err_out
);

   localparam int c_BW = (PKG_LEN   > 1) ? $clog2(PKG_LEN)   : 1;
   localparam int c_PW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int c_OW = (OUT_LEN   > 1) ? $clog2(OUT_LEN)   : 1;
   localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(PKG_LEN - 1);
   localparam logic [c_PW-1:0] c_PKG_LAST  = c_PW'(NUM_STEPS - 1);
   localparam logic [c_OW-1:0] c_OUT_LAST  = c_OW'(OUT_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FWD   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_grant;
   logic            w_grant_nxt;
   logic            r_ptr;
   logic            w_start;
   logic [c_BW-1:0] r_beat_cnt;
   logic [c_PW-1:0] r_pkg_cnt;
   logic [c_OW-1:0] r_out_cnt;

   logic w_fwd, w_active, w_src_valid, w_src_tlast;
   logic w_m_hs, w_r_hs, w_beat_last, w_pkg_last, w_out_last;
   logic w_in_end, w_set_end;

   // Handshakes are built from inputs and state only, never from the outputs
   assign w_fwd       = (r_state == S_FWD);
   assign w_active    = (r_state != S_IDLE);
   assign w_src_valid = r_grant ? s1_axis_tvalid : s0_axis_tvalid;
   assign w_src_tlast = r_grant ? s1_axis_tlast  : s0_axis_tlast;
   assign w_m_hs      = w_fwd & w_src_valid & m_axis_tready;
   assign w_r_hs      = w_active & r_axis_tvalid & o_axis_tready;
   assign w_beat_last = (r_beat_cnt == c_BEAT_LAST);
   assign w_pkg_last  = (r_pkg_cnt == c_PKG_LAST);
   assign w_out_last  = (r_out_cnt == c_OUT_LAST);
   assign w_in_end    = w_m_hs & w_beat_last & w_pkg_last;
   assign w_set_end   = (r_state == S_DRAIN) & w_r_hs & w_out_last;
   assign busy        = w_active;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_grant <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_start        = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      r_axis_tready  = 1'b0;
      o_axis_tdata   = '0;
      o_axis_tvalid  = 1'b0;
      o_axis_tlast   = 1'b0;
      o_axis_tdest   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s0_axis_tvalid | s1_axis_tvalid) begin
               w_start     = 1'b1;
               w_state_nxt = S_FWD;
               w_grant_nxt = (s0_axis_tvalid & s1_axis_tvalid) ? r_ptr : s1_axis_tvalid;
            end
         end
         S_FWD: begin
            m_axis_tdata   = r_grant ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tvalid  = w_src_valid;
            m_axis_tlast   = w_beat_last;
            s0_axis_tready = ~r_grant & m_axis_tready;
            s1_axis_tready = r_grant & m_axis_tready;
            if (w_in_end) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_set_end) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // The core may start returning phase data while input is still flowing
      if (w_active) begin
         o_axis_tdata  = r_axis_tdata;
         o_axis_tvalid = r_axis_tvalid;
         r_axis_tready = o_axis_tready;
         o_axis_tlast  = w_out_last;
         o_axis_tdest  = r_grant;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_beat_cnt <= '0;
         r_pkg_cnt  <= '0;
         r_out_cnt  <= '0;
         r_ptr      <= 1'b0;
         set_done   <= 1'b0;
         err_len    <= 1'b0;
         err_out    <= 1'b0;
      end else begin
         set_done <= w_set_end;
         err_len  <= w_m_hs & (w_src_tlast != w_beat_last);
         err_out  <= w_r_hs & (r_axis_tlast != w_out_last);
         if (w_start) begin
            r_beat_cnt <= '0;
            r_pkg_cnt  <= '0;
            r_out_cnt  <= '0;
         end else begin
            if (w_m_hs) begin
               r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + c_BW'(1);
               if (w_beat_last) r_pkg_cnt <= w_pkg_last ? '0 : r_pkg_cnt + c_PW'(1);
            end
            if (w_r_hs) r_out_cnt <= w_out_last ? '0 : r_out_cnt + c_OW'(1);
         end
         if (w_in_end) r_ptr <= ~r_grant;
      end
   end

endmodule
`default_nettype wire

// File: doc/pmp_phase_sched.md
# pmp_phase_sched

Two-source scheduler in front of the shared `cal_rel_phase` core in the PMP role. It arbitrates between two camera streams (s0, s1), each delivering sets of NUM_STEPS phase-shifted packages. A granted source owns the core for one complete set, from its first input beat until the core has returned the whole phase output. The block regenerates package framing, tags the returned phase stream with its source, and flags framing errors.

## Interface
Parameters:
- BEAT_SIZE, 8, pixels per beat
- DATA_WIDTH, 16, bits per pixel lane
- PKG_LEN, 128, input beats per package
- NUM_STEPS, 4, packages per set
- OUT_LEN, 256, core output beats per set

Ports:
- aclk  in  1  clock; all logic on its rising edge
- areset  in  1  asynchronous, active-high reset
- s0_axis_tdata / s1_axis_tdata  in  BEAT_SIZE*DATA_WIDTH  source pixel data
- s0_axis_tvalid / s1_axis_tvalid  in  1  source valid
- s0_axis_tready / s1_axis_tready  out  1  source ready
- s0_axis_tlast / s1_axis_tlast  in  1  source end-of-package; checked only, never forwarded
- m_axis_tdata  out  BEAT_SIZE*DATA_WIDTH  to core input
- m_axis_tvalid  out  1  to core input
- m_axis_tready  in  1  from core input
- m_axis_tlast  out  1  to core input
- r_axis_tdata  in  BEAT_SIZE*DATA_WIDTH  core phase output
- r_axis_tvalid  in  1  core phase output
- r_axis_tready  out  1  core phase output
- r_axis_tlast  in  1  core phase output
- o_axis_tdata  out  BEAT_SIZE*DATA_WIDTH  tagged phase stream
- o_axis_tvalid  out  1  tagged phase stream
- o_axis_tready  in  1  tagged phase stream
- o_axis_tlast  out  1  tagged phase stream
- o_axis_tdest  out  1  source id of the current set
- busy  out  1  state != IDLE
- set_done  out  1  one-cycle pulse when a set completes
- err_len  out  1  one-cycle pulse on input tlast mismatch
- err_out  out  1  one-cycle pulse on core output tlast mismatch

## Operation
State machine:
- **IDLE.** A grant is computed from the tvalid signals:
  - if exactly one source is valid, that source is granted;
  - if both are valid, the source the round-robin pointer selects is granted;
  - on a grant: latch `grant`, clear all counters, go to FWD.
- **FWD.** Input passthrough, combinational:
  - m_axis_tdata/tvalid are taken from the granted source;
  - granted tready = m_axis_tready; the other tready = 0.
- **FWD counters.** beat_cnt (0..PKG_LEN-1) and pkg_cnt (0..NUM_STEPS-1) advance on each m handshake.
- **FWD framing.** m_axis_tlast = (beat_cnt == PKG_LEN-1). It is generated internally, independent of the source tlast.
- **FWD exit.** On the handshake with beat_cnt == PKG_LEN-1 and pkg_cnt == NUM_STEPS-1, go to DRAIN.
  - The round-robin pointer then points to the other source.
- **DRAIN.** m_axis_tvalid = 0; both source treadies = 0.
  - Leave DRAIN on the r handshake with out_cnt == OUT_LEN-1.
  - Then go to IDLE and pulse set_done on the next cycle.
- **Output path, active in FWD and DRAIN:**
  - o_axis_tdata/tvalid = r_axis_tdata/tvalid, and r_axis_tready = o_axis_tready (combinational);
  - o_axis_tdest = grant;
  - o_axis_tlast = (out_cnt == OUT_LEN-1);
  - out_cnt (0..OUT_LEN-1) advances on each r handshake.
- **Output path, in IDLE.** r_axis_tready = 0 and o_axis_tvalid = 0.
- **err_len** pulses the cycle after a granted-source handshake where s*_axis_tlast != m_axis_tlast.
- **err_out** pulses the cycle after an r handshake where r_axis_tlast != o_axis_tlast.
- **Error handling.** No error changes the state or the counters.

## Timing
- **Reset values.** All outputs 0; state IDLE; counters 0; grant = 0; pointer selects s0.
- **Reset while asserted.** areset forces the reset values immediately, including mid-set. No partial set resumes after release.
- **IDLE→FWD.** One cycle. The first tready is asserted the cycle after a valid source is seen in IDLE.
- **Latency.** Zero cycles for data on both the input and output passthroughs.
- **set_done.** Asserted exactly one cycle after the final o handshake, for one cycle. busy falls in that same cycle.
- **Back-to-back sets.** A source still valid at the return to IDLE is re-arbitrated with the updated pointer.
  - Minimum gap between sets: one IDLE cycle.
- **Stalls.** tvalid low or tready low holds all counters; no beat is dropped or duplicated.
- **Minimum input time.** Input set length is NUM_STEPS*PKG_LEN handshakes, so FWD lasts at least 512 cycles by default.

## Test plan
- **Single source.** s0 sends 512 beats; core stub returns 256 beats; all readies high.
  - m_axis_tlast on input beats 127, 255, 383 and 511.
  - o_axis_tdest = 0; o_axis_tlast on output beat 255.
  - set_done high one cycle after that beat; busy then 0.
- **Contention.** Both sources valid from reset, running three sets.
  - s0 is served first; s1_axis_tready stays 0 through s0's FWD and DRAIN.
  - s1 is served next with o_axis_tdest = 1; the third set goes to s0.
- **Short package.** s0 tlast on beat 100 of package 0.
  - err_len pulses once.
  - m_axis_tlast still appears at beat 127; set completes normally.
- **Backpressure.** m_axis_tready and o_axis_tready driven by pseudo-random 50% patterns.
  - Scoreboard sees exactly 512 input and 256 output beats, in order with unchanged data.
  - No err pulses.
- **Reset mid-set.** areset asserted during package 2, beat 40, for 3 cycles.
  - All outputs 0 within the reset cycle.
  - After release, a new set starts at beat 0, package 0, with s0 priority.
- **Core tlast mismatch.** Core stub asserts r_axis_tlast at output beat 200.
  - err_out pulses once.
  - o_axis_tlast still at beat 255; set_done fires normally.
